// File: rtl/fifo_uart_tx_if.sv
// FIFO read port between the circular FIFO and its UART drain stage.
// master = drain stage (issues pops), slave = FIFO (supplies flag and data).
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;

  modport master (input fifo_empty, input fifo_rd_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_rd_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops words from a 1-cycle-latency FIFO read port and sends them LSB-first as UART frames.
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_N  = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
  localparam int BIT_W  = (BIT_N > 1) ? $clog2(BIT_N) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST   = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST   = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd5
`ifdef PARITY_EN
    , PARITY = 3'd6
`endif
  } state_t;

  state_t             state_r, state_s;
  logic [BAUD_W-1:0]  baud_r, baud_s;
  logic [BIT_W-1:0]   bit_r, bit_s;
  logic [WIDTH-1:0]   shreg_r, shreg_s;
  logic               tx_r, tx_s;
  logic               busy_r, busy_s;
  logic               rd_en_r, rd_en_s;
  logic               done_r, done_s;
  logic               fetch_ok_s;

`ifdef PARITY_EN
  logic parity_r;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // Parity of the word captured in LOAD, held for the PARITY bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else if (state_r == LOAD) begin
      parity_r <= even_parity(fifo.fifo_rd_data);
    end
  end
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      baud_r  <= '0;
      bit_r   <= '0;
      shreg_r <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      rd_en_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      rd_en_r <= rd_en_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_s      = bit_r;
    shreg_s    = shreg_r;
    tx_s       = 1'b1;
    busy_s     = 1'b1;
    rd_en_s    = 1'b0;
    fetch_ok_s = enable && !fifo.fifo_empty;

    case (state_r)
      IDLE: begin
        if (fetch_ok_s) state_s = FETCH;
        else            state_s = IDLE;
      end
      FETCH: state_s = LOAD;
      LOAD: begin
        shreg_s = fifo.fifo_rd_data;
        baud_s  = '0;
        bit_s   = '0;
        state_s = START;
      end
      START: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          state_s = DATA;
        end else begin
          baud_s = baud_r + 1'b1;
        end
      end
      DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
          if (bit_r == DATA_LAST) begin
            bit_s = '0;
`ifdef PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + 1'b1;
          end
        end else begin
          baud_s = baud_r + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          state_s = STOP;
        end else begin
          baud_s = baud_r + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (bit_r == STOP_LAST) begin
            bit_s   = '0;
            state_s = fetch_ok_s ? FETCH : IDLE;
          end else begin
            bit_s = bit_r + 1'b1;
          end
        end else begin
          baud_s = baud_r + 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase

    case (state_s)
      IDLE:    busy_s  = 1'b0;
      FETCH:   rd_en_s = 1'b1;
      START:   tx_s    = 1'b0;
      DATA:    tx_s    = shreg_s[0];
`ifdef PARITY_EN
      PARITY:  tx_s    = parity_r;
`endif
      default: tx_s    = 1'b1;
    endcase

    // Registered pulse must land in the final stop cycle, so decode one cycle early.
    done_s = (state_r == STOP) && (baud_r == BAUD_PENULT) && (bit_r == STOP_LAST);
  end

  assign tx              = tx_r;
  assign busy            = busy_r;
  assign tx_done         = done_r;
  assign fifo.fifo_rd_en = rd_en_r;
endmodule
